// File: rtl/carregador_cromossomo.sv
// Chromosome loader: collects NUM_BYTES serial bytes plus an XOR checksum byte and commits
// the assembled chromosome atomically only when the checksum matches.
module carregador_cromossomo #(
  parameter int unsigned CHROM_BITS = 335
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [CHROM_BITS-1:0] cromossomo,
  output logic                  novo_cromossomo,
  output logic                  erro_checksum,
  output logic                  ocupado
);

  localparam int unsigned NUM_BYTES = (CHROM_BITS + 7) / 8;
  localparam int unsigned CNT_W     = $clog2(NUM_BYTES + 1);
  localparam int unsigned IDX_W     = $clog2(CHROM_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES);

  typedef enum logic [1:0] {
    StOcioso,
    StCarregando,
    StVerifica
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            xor_q, xor_d;
  logic [CHROM_BITS-1:0] staging_q, staging_d;
  logic                  ok_q, ok_d;
  logic [CHROM_BITS-1:0] crom_q, crom_d;
  logic                  novo_q, novo_d;
  logic                  erro_q, erro_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    xor_d     = xor_q;
    staging_d = staging_q;
    ok_d      = ok_q;
    crom_d    = crom_q;
    novo_d    = 1'b0;
    erro_d    = 1'b0;
    unique case (state_q)
      StOcioso: begin
        if (start) begin
          state_d   = StCarregando;
          cnt_d     = '0;
          xor_d     = '0;
          staging_d = '0;
        end
      end
      StCarregando: begin
        // abort wins over a byte offered in the same cycle
        if (abort) begin
          state_d = StOcioso;
        end else if (byte_valid) begin
          if (cnt_q == LAST_CNT) begin
            ok_d    = (byte_in == xor_q);
            state_d = StVerifica;
          end else begin
            cnt_d = cnt_q + 1'b1;
            xor_d = xor_q ^ byte_in;
            // bits past CHROM_BITS still feed the checksum but are not stored
            for (int unsigned k = 0; k < NUM_BYTES; k++) begin
              for (int unsigned b = 0; b < 8; b++) begin
                if (cnt_q == CNT_W'(k) && (8 * k + b) < CHROM_BITS) begin
                  staging_d[IDX_W'(8 * k + b)] = byte_in[3'(b)];
                end
              end
            end
          end
        end
      end
      StVerifica: begin
        state_d = StOcioso;
        if (ok_q) begin
          crom_d = staging_q;
          novo_d = 1'b1;
        end else begin
          erro_d = 1'b1;
        end
      end
      default: state_d = StOcioso;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StOcioso;
      cnt_q     <= '0;
      xor_q     <= '0;
      staging_q <= '0;
      ok_q      <= 1'b0;
      crom_q    <= '0;
      novo_q    <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      xor_q     <= xor_d;
      staging_q <= staging_d;
      ok_q      <= ok_d;
      crom_q    <= crom_d;
      novo_q    <= novo_d;
      erro_q    <= erro_d;
    end
  end

  assign byte_ready      = (state_q == StCarregando);
  assign ocupado         = (state_q == StCarregando);
  assign cromossomo      = crom_q;
  assign novo_cromossomo = novo_q;
  assign erro_checksum   = erro_q;

endmodule

// File: tb/tb_carregador_cromossomo.sv
// Directed bench for carregador_cromossomo: nominal, bad checksum, discarded bit, abort,
// stalls with stray start pulses, and asynchronous reset mid-load.
module tb_carregador_cromossomo;

  localparam int unsigned CB = 335;
  localparam int unsigned NB = 42;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [CB-1:0] cromossomo;
  logic          novo_cromossomo;
  logic          erro_checksum;
  logic          ocupado;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]    d [NB];
  logic [CB-1:0] exp_nom;
  logic [CB-1:0] exp_cur;
  logic [7:0]    chk;

  carregador_cromossomo dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .cromossomo      (cromossomo),
    .novo_cromossomo (novo_cromossomo),
    .erro_checksum   (erro_checksum),
    .ocupado         (ocupado)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [CB-1:0] model();
    logic [CB-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) begin
      for (int b = 0; b < 8; b++) begin
        if (8 * k + b < CB) r[8 * k + b] = d[k][b];
      end
    end
    return r;
  endfunction

  task automatic send(input logic [7:0] b, input bit stalls);
    int g;
    if (stalls) begin
      g = $urandom_range(0, 5);
      byte_valid = 1'b0;
      repeat (g) begin
        start = 1'($urandom_range(0, 1));
        tick();
      end
      start = 1'b0;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] c, input bit stalls);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NB; k++) send(d[k], stalls);
    send(c, stalls);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; byte_in = '0; byte_valid = 1'b0;
    tick();
    tick();
    check("rst_ready", 512'(byte_ready), 512'(0));
    check("rst_ocupado", 512'(ocupado), 512'(0));
    check("rst_novo", 512'(novo_cromossomo), 512'(0));
    check("rst_erro", 512'(erro_checksum), 512'(0));
    check("rst_crom", 512'(cromossomo), 512'(0));
    rst = 1'b0;
    tick();

    // Nominal load with exact latency
    for (int k = 0; k < NB; k++) d[k] = 8'(k + 1);
    exp_nom = model();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("nom_ocupado", 512'(ocupado), 512'(1));
    check("nom_ready", 512'(byte_ready), 512'(1));
    for (int k = 0; k < NB; k++) send(d[k], 1'b0);
    check("nom_crom_hidden", 512'(cromossomo), 512'(0));
    send(8'h2B, 1'b0);
    check("nom_novo_early", 512'(novo_cromossomo), 512'(0));
    check("nom_verifica_not_busy", 512'(ocupado), 512'(0));
    tick();
    check("nom_novo", 512'(novo_cromossomo), 512'(1));
    check("nom_erro", 512'(erro_checksum), 512'(0));
    check("nom_lsb", 512'(cromossomo[7:0]), 512'(8'h01));
    check("nom_msb", 512'(cromossomo[334:328]), 512'(7'h2A));
    check("nom_full", 512'(cromossomo), 512'(exp_nom));
    tick();
    check("nom_novo_once", 512'(novo_cromossomo), 512'(0));

    // Bad checksum
    load(8'h00, 1'b0);
    tick();
    check("bad_erro", 512'(erro_checksum), 512'(1));
    check("bad_novo", 512'(novo_cromossomo), 512'(0));
    check("bad_crom", 512'(cromossomo), 512'(exp_nom));
    tick();
    check("bad_erro_once", 512'(erro_checksum), 512'(0));

    // All ones: top bit of the last byte is discarded, XOR of 42 x FF is 00
    for (int k = 0; k < NB; k++) d[k] = 8'hFF;
    load(8'h00, 1'b0);
    tick();
    check("ff_novo", 512'(novo_cromossomo), 512'(1));
    check("ff_crom", 512'(cromossomo), 512'({CB{1'b1}}));
    exp_cur = {CB{1'b1}};

    // Abort on the 20th transfer
    for (int k = 0; k < NB; k++) d[k] = 8'(k + 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 19; k++) send(d[k], 1'b0);
    abort = 1'b1; byte_in = d[19]; byte_valid = 1'b1;
    tick();
    abort = 1'b0; byte_valid = 1'b0;
    check("abort_ocupado", 512'(ocupado), 512'(0));
    check("abort_ready", 512'(byte_ready), 512'(0));
    check("abort_crom", 512'(cromossomo), 512'(exp_cur));
    tick();
    check("abort_no_novo", 512'(novo_cromossomo), 512'(0));
    check("abort_no_erro", 512'(erro_checksum), 512'(0));
    // abort while idle must not disturb a following load
    abort = 1'b1;
    tick();
    abort = 1'b0;
    load(8'h2B, 1'b0);
    tick();
    check("abort_reload_novo", 512'(novo_cromossomo), 512'(1));
    check("abort_reload_crom", 512'(cromossomo), 512'(exp_nom));

    // Stalls with stray start pulses, different data, start held in VERIFICA
    chk = '0;
    for (int k = 0; k < NB; k++) begin
      d[k] = 8'((k * 37 + 11) & 8'hFF);
      chk  = chk ^ d[k];
    end
    exp_cur = model();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NB; k++) send(d[k], 1'b1);
    check("stall_not_early", 512'(novo_cromossomo), 512'(0));
    send(chk, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("stall_novo", 512'(novo_cromossomo), 512'(1));
    check("stall_crom", 512'(cromossomo), 512'(exp_cur));
    check("verifica_start_ignored", 512'(ocupado), 512'(0));
    tick();
    check("verifica_start_still_idle", 512'(ocupado), 512'(0));

    // Async reset mid-cycle after the 30th byte
    for (int k = 0; k < NB; k++) d[k] = 8'(k + 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 30; k++) send(d[k], 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_ocupado", 512'(ocupado), 512'(0));
    check("arst_ready", 512'(byte_ready), 512'(0));
    check("arst_crom", 512'(cromossomo), 512'(0));
    tick();
    rst = 1'b0;
    tick();
    check("arst_no_resume", 512'(ocupado), 512'(0));
    load(8'h2B, 1'b0);
    tick();
    check("arst_reload_novo", 512'(novo_cromossomo), 512'(1));
    check("arst_reload_crom", 512'(cromossomo), 512'(exp_nom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/carregador_cromossomo.md
CARREGADOR_CROMOSSOMO -- requirements
Module: carregador_cromossomo

Interface
REQ-001 Parameter CHROM_BITS, default 335, width of the chromosome bus driven to the phenotype decoder.
REQ-002 Local parameter NUM_BYTES = ceil(CHROM_BITS/8), which is 42 at the default; it is not overridable.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a chromosome load.
REQ-006 abort  input  1  cancels the load in progress.
REQ-007 byte_in  input  8  serial chromosome data byte.
REQ-008 byte_valid  input  1  byte_in holds valid data.
REQ-009 byte_ready  output  1  the block accepts a byte this cycle.
REQ-010 cromossomo  output  CHROM_BITS  committed chromosome; drives the phenotype decoder.
REQ-011 novo_cromossomo  output  1  one-cycle pulse: cromossomo was updated.
REQ-012 erro_checksum  output  1  one-cycle pulse: load rejected because of checksum mismatch.
REQ-013 ocupado  output  1  high while the state is CARREGANDO.

Function
REQ-014 The FSM shall have exactly three states: OCIOSO, CARREGANDO and VERIFICA.
REQ-015 A byte transfer shall occur only on a cycle with byte_valid=1 and byte_ready=1.
REQ-016 byte_ready shall be 1 only in state CARREGANDO, as a registered or state-decoded signal with no combinational path from byte_valid.
REQ-017 OCIOSO, start=1: the block shall go to CARREGANDO and clear the byte counter, the staging register and the running XOR.
REQ-018 start shall be ignored in CARREGANDO and in VERIFICA.
REQ-019 Transfer k (k=0..NUM_BYTES-1) shall write byte_in into staging bits [8k+7:8k], so the first byte lands at the LSBs.
REQ-020 Staging bits at or above CHROM_BITS shall be discarded; at the default this is bit 7 of byte 41.
REQ-021 Every data byte (all 8 bits, including any discarded bits) shall be XORed into an 8-bit running checksum.
REQ-022 Transfer number NUM_BYTES (the 43rd byte at the default) shall be the checksum byte; the block shall compare it to the running XOR and go to VERIFICA.
REQ-023 VERIFICA shall last exactly one cycle, then return to OCIOSO.
  - Match: cromossomo <= staging; novo_cromossomo pulses.
  - Mismatch: cromossomo unchanged; erro_checksum pulses.
REQ-024 novo_cromossomo and erro_checksum shall never be high in the same cycle.
REQ-025 Each shall be high for exactly one cycle per load.
REQ-026 cromossomo shall change only in the VERIFICA commit; a partially loaded chromosome shall never be visible on the output.
REQ-027 Latency: with byte_valid held high, the commit is visible 1 cycle after the checksum transfer, i.e. NUM_BYTES+2 cycles after start.
REQ-028 Gaps (byte_valid=0) shall stall the counter for any number of cycles; there is no timeout.
REQ-029 abort=1 in CARREGANDO shall return to OCIOSO next cycle, leave cromossomo unchanged and produce no pulse.
REQ-030 abort takes priority over a simultaneous byte transfer; that byte shall be dropped.
REQ-031 abort in OCIOSO or VERIFICA shall be ignored.
REQ-032 The byte counter shall be ceil(log2(NUM_BYTES+1)) bits wide and shall never wrap: it stops at NUM_BYTES.
REQ-033 start=1 in the VERIFICA cycle shall be ignored; a new load requires start in OCIOSO.

Reset
REQ-034 On rst=1, immediately and asynchronously:
  - state = OCIOSO
  - counter = 0, running XOR = 0, staging = 0
  - cromossomo = 0
  - byte_ready = 0, novo_cromossomo = 0, erro_checksum = 0, ocupado = 0
REQ-035 rst asserted mid-load shall discard the load; the load does not resume after rst deasserts.

Verification
REQ-036 Nominal load: start, then bytes 0x01..0x2A with valid held high, then checksum 0x2B (the XOR of 0x01..0x2A). Required: cromossomo[7:0]=0x01, cromossomo[334:328]=0x2A; novo_cromossomo pulses in cycle 44 after start.
REQ-037 Bad checksum: load the same bytes with checksum 0x00. Required: erro_checksum pulses once; cromossomo keeps its previous value; no novo_cromossomo.
REQ-038 Discarded bit: all 42 data bytes = 0xFF, checksum 0x00. Required: commit with cromossomo all ones (335 bits); bit 335 is absent from the output.
REQ-039 Abort: abort on the cycle of the 20th transfer. Required: OCIOSO the next cycle; ocupado=0; cromossomo unchanged; a following full load with correct checksum succeeds.
REQ-040 Stalls and ignored start: random byte_valid gaps (up to 5 cycles) plus start pulses during CARREGANDO. Required: same result as the nominal load; byte count unaffected.
REQ-041 Async reset: rst asserted mid-cycle after the 30th byte. Required: outputs clear before the next clock edge; a subsequent start with a full, correct load commits correctly.
